// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file read pipeline.
// Optional feature macro: RF_READ_PARITY_EN (adds per-operand parity to responses).
package rf_pkg;

   localparam int NREGS    = 32;
   localparam int DW       = 64;
   localparam int TAGW     = 6;
   localparam int AW       = $clog2(NREGS);
   localparam int ZERO_REG = NREGS - 1;

   typedef logic [AW-1:0] reg_idx_t;

   localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

   // One buffered response: operand snapshots plus the request's tag.
   typedef struct packed {
      logic [DW-1:0]   a;
      logic [DW-1:0]   b;
      logic [TAGW-1:0] tag;
`ifdef RF_READ_PARITY_EN
      logic            par_a;
      logic            par_b;
`endif
   } rf_rsp_t;

   // Occupancy of the 2-entry response buffer.
   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } fifo_cnt_e;

   // Even parity of an operand is the XOR reduction of its bits.
   function automatic logic even_parity(input logic [DW-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/regfile_read_pipe_if.sv
// Bundle of write port, read-request channel and response channel.
// Optional feature macro: RF_READ_PARITY_EN (adds rsp_par_a / rsp_par_b).
interface regfile_read_pipe_if;
   import rf_pkg::*;

   logic            wr_en;
   reg_idx_t        wr_addr;
   logic [DW-1:0]   wr_data;

   logic            req_valid;
   logic            req_ready;
   reg_idx_t        req_ra;
   reg_idx_t        req_rb;
   logic [TAGW-1:0] req_tag;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_a;
   logic [DW-1:0]   rsp_b;
   logic [TAGW-1:0] rsp_tag;
`ifdef RF_READ_PARITY_EN
   logic            rsp_par_a;
   logic            rsp_par_b;
`endif

   modport master (
      output wr_en, wr_addr, wr_data,
      output req_valid, req_ra, req_rb, req_tag,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid, rsp_a, rsp_b, rsp_tag
`ifdef RF_READ_PARITY_EN
      , input rsp_par_a, rsp_par_b
`endif
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  req_valid, req_ra, req_rb, req_tag,
      input  rsp_ready,
      output req_ready,
      output rsp_valid, rsp_a, rsp_b, rsp_tag
`ifdef RF_READ_PARITY_EN
      , output rsp_par_a, rsp_par_b
`endif
   );

endinterface

// File: rtl/rf_rsp_fifo2.sv
// Two-entry ordered response buffer; the head entry drives the outputs.
// A full buffer still accepts when the head is popped in the same cycle.
module rf_rsp_fifo2
   import rf_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    in_valid,
   output logic    in_ready,
   input  rf_rsp_t in_data,
   output logic    out_valid,
   input  logic    out_ready,
   output rf_rsp_t out_data
);

   fifo_cnt_e state;
   fifo_cnt_e state_nxt;
   rf_rsp_t   head_q;
   rf_rsp_t   tail_q;
   logic      push;
   logic      pop;

   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign out_data = head_q;

   // Occupancy register; reset empties the buffer immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CNT_EMPTY;
      else     state <= state_nxt;
   end

   // Occupancy moves up on push-only, down on pop-only, holds otherwise.
   always_comb begin
      state_nxt = state;
      case (state)
         CNT_EMPTY: if (push)          state_nxt = CNT_ONE;
         CNT_ONE: begin
            if (push && !pop)          state_nxt = CNT_FULL;
            else if (pop && !push)     state_nxt = CNT_EMPTY;
         end
         CNT_FULL:  if (pop && !push)  state_nxt = CNT_ONE;
         default:                      state_nxt = CNT_EMPTY;
      endcase
   end

   // Handshake flags depend only on occupancy and the consumer's ready.
   always_comb begin
      out_valid = (state != CNT_EMPTY);
      in_ready  = (state != CNT_FULL) || out_ready;
   end

   // Entry storage: a pop shifts tail into head, new data fills the next free slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case (state)
            CNT_EMPTY: if (push) head_q <= in_data;
            CNT_ONE: begin
               if (push && pop) head_q <= in_data;
               else if (push)   tail_q <= in_data;
            end
            CNT_FULL: begin
               if (pop) begin
                  head_q <= tail_q;
                  if (push) tail_q <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/regfile_read_pipe.sv
// Register-file read side: 32 x 64-bit storage, one write port, a handshaked
// two-operand read with same-cycle write bypass and a 2-entry response buffer.
// X31 is hard-wired to zero. Optional feature macro: RF_READ_PARITY_EN.
module regfile_read_pipe
   import rf_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   regfile_read_pipe_if.slave  bus
);

   logic [DW-1:0] mem [NREGS];
   logic          wr_ok;
   logic [DW-1:0] opnd_a;
   logic [DW-1:0] opnd_b;
   rf_rsp_t       snap;
   rf_rsp_t       head;

   assign wr_ok = bus.wr_en && (bus.wr_addr != ZERO_IDX);

   // Register storage; the zero register is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Operand snapshot: zero register first, then same-cycle write bypass, then storage.
   always_comb begin
      opnd_a = mem[bus.req_ra];
      if (bus.req_ra == ZERO_IDX)                  opnd_a = '0;
      else if (wr_ok && bus.wr_addr == bus.req_ra) opnd_a = bus.wr_data;

      opnd_b = mem[bus.req_rb];
      if (bus.req_rb == ZERO_IDX)                  opnd_b = '0;
      else if (wr_ok && bus.wr_addr == bus.req_rb) opnd_b = bus.wr_data;

      snap     = '0;
      snap.a   = opnd_a;
      snap.b   = opnd_b;
      snap.tag = bus.req_tag;
`ifdef RF_READ_PARITY_EN
      snap.par_a = even_parity(opnd_a);
      snap.par_b = even_parity(opnd_b);
`endif
   end

   rf_rsp_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.req_valid),
      .in_ready  (bus.req_ready),
      .in_data   (snap),
      .out_valid (bus.rsp_valid),
      .out_ready (bus.rsp_ready),
      .out_data  (head)
   );

   assign bus.rsp_a   = head.a;
   assign bus.rsp_b   = head.b;
   assign bus.rsp_tag = head.tag;
`ifdef RF_READ_PARITY_EN
   assign bus.rsp_par_a = head.par_a;
   assign bus.rsp_par_b = head.par_b;
`endif

endmodule

// File: tb/tb_regfile_read_pipe.sv
// Self-checking bench for regfile_read_pipe: directed scenarios plus a random
// phase, all compared against a queue/array reference model of the register file.
module tb_regfile_read_pipe;
   import rf_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic last_ready;

   logic [DW-1:0] model_mem [NREGS];
   rf_rsp_t       model_q [$];

   always #5 clk = ~clk;

   regfile_read_pipe_if bus ();

   regfile_read_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string name, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
      end
   endtask

   task automatic checkFlag(input string name, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
   endtask

   task automatic checkTag(input string name, input logic [TAGW-1:0] observed, input logic [TAGW-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
      end
   endtask

   // Architectural read value of a register as seen by a request in a given cycle.
   function automatic logic [DW-1:0] modelRead(input int idx, input logic wen, input int waddr, input logic [DW-1:0] wdata);
      if (idx == ZERO_REG)         return '0;
      if (wen && waddr == idx)     return wdata;
      return model_mem[idx];
   endfunction

   task automatic checkModel();
      checkFlag("rsp_valid", bus.rsp_valid, model_q.size() > 0);
      if (model_q.size() > 0) begin
         checkOutput("rsp_a", bus.rsp_a, model_q[0].a);
         checkOutput("rsp_b", bus.rsp_b, model_q[0].b);
         checkTag("rsp_tag", bus.rsp_tag, model_q[0].tag);
`ifdef RF_READ_PARITY_EN
         checkFlag("rsp_par_a", bus.rsp_par_a, model_q[0].par_a);
         checkFlag("rsp_par_b", bus.rsp_par_b, model_q[0].par_b);
`endif
      end
   endtask

   // Drive one cycle of inputs, check ready before the edge and outputs after it.
   task automatic applyStimulus(input logic wen, input int waddr, input logic [DW-1:0] wdata,
                                input logic rvalid, input int ra, input int rb, input int tag,
                                input logic rready);
      rf_rsp_t e;
      logic    exp_ready;
      logic    accept;
      logic    pop;
      logic [TAGW-1:0] t;
      t = tag[TAGW-1:0];
      bus.wr_en     = wen;
      bus.wr_addr   = reg_idx_t'(waddr);
      bus.wr_data   = wdata;
      bus.req_valid = rvalid;
      bus.req_ra    = reg_idx_t'(ra);
      bus.req_rb    = reg_idx_t'(rb);
      bus.req_tag   = t;
      bus.rsp_ready = rready;
      #1;
      last_ready = bus.req_ready;
      exp_ready  = (model_q.size() < 2) || rready;
      checkFlag("req_ready", last_ready, exp_ready);
      accept = rvalid && exp_ready;
      pop    = (model_q.size() > 0) && rready;
      e      = '0;
      e.a    = modelRead(ra, wen, waddr, wdata);
      e.b    = modelRead(rb, wen, waddr, wdata);
      e.tag  = t;
`ifdef RF_READ_PARITY_EN
      e.par_a = ^e.a;
      e.par_b = ^e.b;
`endif
      @(posedge clk);
      if (pop) void'(model_q.pop_front());
      if (accept) model_q.push_back(e);
      if (wen && waddr != ZERO_REG) model_mem[waddr] = wdata;
      #1;
      checkModel();
   endtask

   task automatic idle(input logic rready);
      applyStimulus(1'b0, 0, '0, 1'b0, 0, 0, 0, rready);
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) model_mem[i] = '0;
      rst           = 1'b1;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.req_valid = 1'b0;
      bus.req_ra    = '0;
      bus.req_rb    = '0;
      bus.req_tag   = '0;
      bus.rsp_ready = 1'b1;
      #2;
      checkFlag("reset_valid", bus.rsp_valid, 1'b0);
      checkOutput("reset_a", bus.rsp_a, 64'h0);
      checkOutput("reset_b", bus.rsp_b, 64'h0);
      checkTag("reset_tag", bus.rsp_tag, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkFlag("reset_ready", bus.req_ready, 1'b1);

      $display("[TB] basic write then read");
      applyStimulus(1'b1, 3, 64'h1122334455667788, 1'b0, 0, 0, 0, 1'b1);
      applyStimulus(1'b0, 0, '0, 1'b1, 3, 31, 5, 1'b1);
      checkFlag("tp1_valid", bus.rsp_valid, 1'b1);
      checkOutput("tp1_a", bus.rsp_a, 64'h1122334455667788);
      checkOutput("tp1_b", bus.rsp_b, 64'h0);
      checkTag("tp1_tag", bus.rsp_tag, 6'd5);

      $display("[TB] bypass and zero register");
      applyStimulus(1'b1, 7, 64'hAAAA, 1'b1, 7, 7, 6, 1'b1);
      checkOutput("bypass_a", bus.rsp_a, 64'hAAAA);
      checkOutput("bypass_b", bus.rsp_b, 64'hAAAA);
      applyStimulus(1'b1, 31, 64'hFF, 1'b0, 0, 0, 0, 1'b1);
      applyStimulus(1'b1, 31, 64'h55, 1'b1, 31, 31, 7, 1'b1);
      checkOutput("x31_a", bus.rsp_a, 64'h0);
      checkOutput("x31_b", bus.rsp_b, 64'h0);
      idle(1'b1);

      $display("[TB] stall with write to a buffered register");
      applyStimulus(1'b0, 0, '0, 1'b1, 1, 2, 1, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1, 1, 2, 2, 1'b0);
      applyStimulus(1'b1, 1, 64'hBEEF, 1'b1, 1, 2, 3, 1'b0);
      checkFlag("stall_ready", last_ready, 1'b0);
      checkTag("stall_head_tag", bus.rsp_tag, 6'd1);
      checkOutput("stall_head_a", bus.rsp_a, 64'h0);
      applyStimulus(1'b0, 0, '0, 1'b1, 1, 2, 3, 1'b1);
      checkFlag("release_ready", last_ready, 1'b1);
      checkTag("release_tag2", bus.rsp_tag, 6'd2);
      checkOutput("release_a2", bus.rsp_a, 64'h0);
      idle(1'b1);
      checkTag("release_tag3", bus.rsp_tag, 6'd3);
      checkOutput("release_a3", bus.rsp_a, 64'hBEEF);
      idle(1'b1);

      $display("[TB] back-to-back push and pop on a full buffer");
      applyStimulus(1'b0, 0, '0, 1'b1, 1, 3, 10, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1, 3, 7, 11, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), {$urandom, $urandom},
                       1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 12 + i, 1'b1);
         checkFlag("b2b_ready", last_ready, 1'b1);
         checkTag("b2b_order", bus.rsp_tag, TAGW'(11 + i));
      end
      idle(1'b1);
      idle(1'b1);

`ifdef RF_READ_PARITY_EN
      $display("[TB] parity");
      applyStimulus(1'b1, 5, 64'h7, 1'b0, 0, 0, 0, 1'b1);
      applyStimulus(1'b1, 6, 64'h3, 1'b1, 5, 6, 8, 1'b1);
      checkFlag("par_7", bus.rsp_par_a, 1'b1);
      applyStimulus(1'b0, 0, '0, 1'b1, 6, 5, 9, 1'b1);
      checkFlag("par_3", bus.rsp_par_a, 1'b0);
      idle(1'b1);
`endif

      $display("[TB] random traffic");
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), {$urandom, $urandom},
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
      end
      idle(1'b1);
      idle(1'b1);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b0, 0, '0, 1'b1, 4, 5, 40, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1, 6, 8, 41, 1'b0);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd9;
      bus.wr_data = 64'hDEAD;
      rst = 1'b1;
      #1;
      checkFlag("midrst_valid", bus.rsp_valid, 1'b0);
      checkOutput("midrst_a", bus.rsp_a, 64'h0);
      checkTag("midrst_tag", bus.rsp_tag, '0);
      model_q.delete();
      for (int i = 0; i < NREGS; i++) model_mem[i] = '0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.wr_en = 1'b0;
      #1;
      checkFlag("midrst_ready", bus.req_ready, 1'b1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 0, '0, 1'b1, 2 * i, 2 * i + 1, i, 1'b1);
         checkOutput("postrst_a", bus.rsp_a, 64'h0);
         checkOutput("postrst_b", bus.rsp_b, 64'h0);
      end
      idle(1'b1);
      checkFlag("final_valid", bus.rsp_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
